// File: rtl/word_rx.sv
// word_rx: bit-serial 16-bit word receiver feeding a valid/ready consumer.
// Frame: start bit, 16 data bits LSB first, [even parity], stop bit.
// Optional feature macro: WORD_RX_PARITY_EN (adds the PARITY state and the
// parityerr port; without it a frame is 18 bits long).
module word_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] clkdiv,
    output logic [15:0] out,
    output logic        outvalid,
    input  logic        outready,
    output logic        busy,
    output logic        frameerr,
    output logic        overrun,
    input  logic        clrerr
`ifdef WORD_RX_PARITY_EN
    ,
    output logic        parityerr
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_WAITHI = 3'd5
`ifdef WORD_RX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            div_q, div_d;
    logic [3:0]             bitn_q, bitn_d;
    logic [15:0]            shreg_q, shreg_d;
    logic [15:0]            out_q, out_d;
    logic                   outvalid_q, outvalid_d;
    logic                   busy_q, busy_d;
    logic                   frameerr_q, frameerr_d;
    logic                   overrun_q, overrun_d;
    logic                   rxs_s;
    logic                   deliver_s;
    logic                   frame_set_s;
    logic                   overrun_set_s;
`ifdef WORD_RX_PARITY_EN
    logic                   parityerr_q, parityerr_d;
    logic                   par_set_s;
`endif

    // Synchroniser shift: the oldest stage is the line value used everywhere.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
        rxs_s  = sync_q[SYNC_STAGES-1];
    end

    // Frame FSM: bit timing, sampling and next-state selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bitn_d      = bitn_q;
        shreg_d     = shreg_q;
        deliver_s   = 1'b0;
        frame_set_s = 1'b0;
`ifdef WORD_RX_PARITY_EN
        par_set_s   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rxs_s == 1'b0) begin
                    // The divider is frozen for the whole frame.
                    div_d   = clkdiv;
                    cnt_d   = 16'd0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == (div_q >> 1)) begin
                    if (rxs_s == 1'b0) begin
                        cnt_d   = 16'd0;
                        bitn_d  = 4'd0;
                        state_d = ST_DATA;
                    end else begin
                        // Start bit vanished before mid-bit: glitch, no flag.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == div_q) begin
                    shreg_d[bitn_q] = rxs_s;
                    cnt_d           = 16'd0;
                    bitn_d          = bitn_q + 4'd1;
                    if (bitn_q == 4'd15) begin
`ifdef WORD_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef WORD_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == div_q) begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_set_s = (^shreg_q) ^ rxs_s;
                    cnt_d     = 16'd0;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == div_q) begin
                    cnt_d = 16'd0;
                    if (rxs_s == 1'b1) begin
                        deliver_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_set_s = 1'b1;
                        state_d     = ST_WAITHI;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAITHI: begin
                if (rxs_s == 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAITHI;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output port: delivery, transfer, sticky error flags and busy.
    always_comb begin
        out_d         = out_q;
        outvalid_d    = outvalid_q;
        overrun_set_s = 1'b0;
        if (deliver_s) begin
            if (!outvalid_q || outready) begin
                out_d      = shreg_q;
                outvalid_d = 1'b1;
            end else begin
                // Consumer still holds the previous word: keep it, flag loss.
                overrun_set_s = 1'b1;
            end
        end else if (outvalid_q && outready) begin
            outvalid_d = 1'b0;
        end else begin
            outvalid_d = outvalid_q;
        end

        // A same-cycle set wins over clrerr.
        if (frame_set_s) begin
            frameerr_d = 1'b1;
        end else if (clrerr) begin
            frameerr_d = 1'b0;
        end else begin
            frameerr_d = frameerr_q;
        end

        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (clrerr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

`ifdef WORD_RX_PARITY_EN
        if (par_set_s) begin
            parityerr_d = 1'b1;
        end else if (clrerr) begin
            parityerr_d = 1'b0;
        end else begin
            parityerr_d = parityerr_q;
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync_q      <= {SYNC_STAGES{1'b1}};
            cnt_q       <= 16'd0;
            div_q       <= 16'd0;
            bitn_q      <= 4'd0;
            shreg_q     <= 16'd0;
            out_q       <= 16'd0;
            outvalid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frameerr_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef WORD_RX_PARITY_EN
            parityerr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bitn_q      <= bitn_d;
            shreg_q     <= shreg_d;
            out_q       <= out_d;
            outvalid_q  <= outvalid_d;
            busy_q      <= busy_d;
            frameerr_q  <= frameerr_d;
            overrun_q   <= overrun_d;
`ifdef WORD_RX_PARITY_EN
            parityerr_q <= parityerr_d;
`endif
        end
    end

    assign out       = out_q;
    assign outvalid  = outvalid_q;
    assign busy      = busy_q;
    assign frameerr  = frameerr_q;
    assign overrun   = overrun_q;
`ifdef WORD_RX_PARITY_EN
    assign parityerr = parityerr_q;
`endif

endmodule

// File: tb/tb_word_rx.sv
// Directed testbench for word_rx. Drives serial frames on negedges, samples
// outputs on negedges, and compares against hand-computed values.
module tb_word_rx;

    localparam int SYNC = 2;
`ifdef WORD_RX_PARITY_EN
    localparam int LAT_BOUND = SYNC + 4 + 18 * 8;
`else
    localparam int LAT_BOUND = SYNC + 4 + 17 * 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [15:0] clkdiv;
    logic [15:0] out;
    logic        outvalid;
    logic        outready;
    logic        busy;
    logic        frameerr;
    logic        overrun;
    logic        clrerr;
`ifdef WORD_RX_PARITY_EN
    logic        parityerr;
`endif

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   tick_n    = 0;
    int   ov_ticks  = 0;
    int   rise_tick = -1;
    logic busy_seen = 1'b0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    word_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .clkdiv   (clkdiv),
        .out      (out),
        .outvalid (outvalid),
        .outready (outready),
        .busy     (busy),
        .frameerr (frameerr),
        .overrun  (overrun),
        .clrerr   (clrerr)
`ifdef WORD_RX_PARITY_EN
        ,
        .parityerr(parityerr)
`endif
    );

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tick_n++;
        if (outvalid === 1'b1) begin
            ov_ticks++;
            if (rise_tick < 0) rise_tick = tick_n;
        end
        if (busy === 1'b1) busy_seen = 1'b1;
    endtask

    task automatic drive_bit(input logic v, input int p);
        rxd = v;
        repeat (p) tick();
    endtask

    task automatic send_frame(input logic [15:0] d, input logic stopb, input int p);
        drive_bit(1'b0, p);
        for (int i = 0; i < 16; i++) drive_bit(d[i], p);
`ifdef WORD_RX_PARITY_EN
        drive_bit(^d, p);
`endif
        drive_bit(stopb, p);
    endtask

`ifdef WORD_RX_PARITY_EN
    task automatic send_frame_badpar(input logic [15:0] d, input int p);
        drive_bit(1'b0, p);
        for (int i = 0; i < 16; i++) drive_bit(d[i], p);
        drive_bit(~(^d), p);
        drive_bit(1'b1, p);
    endtask
`endif

    initial begin
        int t0;
        int lat;
        logic [15:0] part;

        rst      = 1'b1;
        rxd      = 1'b1;
        outready = 1'b0;
        clrerr   = 1'b0;
        clkdiv   = 16'd7;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check16("rst_out",      out,              16'h0000);
        check16("rst_outvalid", {15'd0, outvalid}, 16'd0);
        check16("rst_busy",     {15'd0, busy},     16'd0);
        check16("rst_frameerr", {15'd0, frameerr}, 16'd0);
        check16("rst_overrun",  {15'd0, overrun},  16'd0);
`ifdef WORD_RX_PARITY_EN
        check16("rst_parityerr", {15'd0, parityerr}, 16'd0);
`endif

        // 0xA55A at clkdiv=7, consumer always ready.
        outready  = 1'b1;
        ov_ticks  = 0;
        rise_tick = -1;
        t0        = tick_n;
        send_frame(16'hA55A, 1'b1, 8);
        drive_bit(1'b1, 4);
        lat = (rise_tick < 0) ? 9999 : (rise_tick - t0 - 1);
        check16("a55a_out",      out, 16'hA55A);
        check16("a55a_ov_ticks", 16'(ov_ticks), 16'd1);
        check16("a55a_lat_ok",   {15'd0, (lat <= LAT_BOUND)}, 16'd1);
        check16("a55a_ov_low",   {15'd0, outvalid}, 16'd0);

        // Back-to-back 0x0001 then 0xFFFF at clkdiv=15, consumer stalled.
        outready = 1'b0;
        clkdiv   = 16'd15;
        send_frame(16'h0001, 1'b1, 16);
        send_frame(16'hFFFF, 1'b1, 16);
        drive_bit(1'b1, 8);
        check16("b2b_out",      out, 16'h0001);
        check16("b2b_outvalid", {15'd0, outvalid}, 16'd1);
        check16("b2b_overrun",  {15'd0, overrun},  16'd1);
        check16("b2b_frameerr", {15'd0, frameerr}, 16'd0);
        clrerr = 1'b1;
        tick();
        clrerr = 1'b0;
        tick();
        check16("clr_overrun",  {15'd0, overrun},  16'd0);
        check16("clr_outvalid", {15'd0, outvalid}, 16'd1);
        outready = 1'b1;
        tick();
        outready = 1'b0;
        tick();
        check16("drain_outvalid", {15'd0, outvalid}, 16'd0);

        // Stop bit low on 0x1234, line held low, then 0x5678.
        clkdiv = 16'd7;
        send_frame(16'h1234, 1'b0, 8);
        drive_bit(1'b0, 40);
        check16("ferr_busy_waithi", {15'd0, busy},     16'd1);
        check16("ferr_frameerr",    {15'd0, frameerr}, 16'd1);
        check16("ferr_outvalid",    {15'd0, outvalid}, 16'd0);
        drive_bit(1'b1, 10);
        check16("ferr_idle_busy",   {15'd0, busy},     16'd0);
        send_frame(16'h5678, 1'b1, 8);
        drive_bit(1'b1, 6);
        check16("after_ferr_out",      out, 16'h5678);
        check16("after_ferr_outvalid", {15'd0, outvalid}, 16'd1);
        check16("after_ferr_sticky",   {15'd0, frameerr}, 16'd1);
        clrerr = 1'b1;
        tick();
        clrerr = 1'b0;
        outready = 1'b1;
        tick();
        outready = 1'b0;
        tick();
        check16("clr_frameerr", {15'd0, frameerr}, 16'd0);

        // Two-cycle glitch at clkdiv=15.
        clkdiv    = 16'd15;
        busy_seen = 1'b0;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 30);
        check16("glitch_busy_seen", {15'd0, busy_seen}, 16'd1);
        check16("glitch_busy",      {15'd0, busy},      16'd0);
        check16("glitch_outvalid",  {15'd0, outvalid},  16'd0);
        check16("glitch_frameerr",  {15'd0, frameerr},  16'd0);
        check16("glitch_overrun",   {15'd0, overrun},   16'd0);

        // Reset in the middle of bit 8, then a clean 0xBEEF.
        clkdiv = 16'd7;
        part   = 16'h1111;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 8; i++) drive_bit(part[i], 8);
        drive_bit(part[8], 4);
        rst = 1'b1;
        rxd = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check16("midrst_out",      out,               16'h0000);
        check16("midrst_outvalid", {15'd0, outvalid}, 16'd0);
        check16("midrst_busy",     {15'd0, busy},     16'd0);
        check16("midrst_frameerr", {15'd0, frameerr}, 16'd0);
        check16("midrst_overrun",  {15'd0, overrun},  16'd0);
        drive_bit(1'b1, 40);
        check16("midrst_quiet", {14'd0, busy, outvalid}, 16'd0);
        send_frame(16'hBEEF, 1'b1, 8);
        drive_bit(1'b1, 6);
        check16("beef_out",      out, 16'hBEEF);
        check16("beef_outvalid", {15'd0, outvalid}, 16'd1);
        check16("beef_flags",    {14'd0, frameerr, overrun}, 16'd0);

`ifdef WORD_RX_PARITY_EN
        // 0x0003 with a wrong parity bit is flagged but still delivered.
        outready = 1'b1;
        tick();
        outready = 1'b0;
        check16("par_clean", {15'd0, parityerr}, 16'd0);
        send_frame_badpar(16'h0003, 8);
        drive_bit(1'b1, 6);
        check16("par_parityerr", {15'd0, parityerr}, 16'd1);
        check16("par_out",       out, 16'h0003);
        check16("par_outvalid",  {15'd0, outvalid}, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
